// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the serial data-bus master stage.
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Access size encodings carried in funct3[1:0]; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Number of serial beats needed to move one 32-bit word at w bits per beat.
  function automatic int unsigned beat_count(input int unsigned w);
    return 32 / w;
  endfunction

endpackage

// File: rtl/serv_dbus_align.sv
// Combinational lane logic: byte enables, store data replication and
// load data shift plus sign/zero extension.
module serv_dbus_align
  import serv_dbus_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lsb,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdt,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdat,
  output logic [31:0] o_rdat
);

  logic [31:0] w_sh;
  logic        w_sext;

  // Select lanes and extend the returned word according to access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    w_sh   = i_rdt >> {i_lsb, 3'b000};
    w_sext = 1'b0;
    o_sel  = 4'b1111;
    o_wdat = i_wdata;
    o_rdat = w_sh;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        w_sext = ~i_funct3[2] & w_sh[7];
        o_sel  = 4'b0001 << i_lsb;
        o_wdat = {4{i_wdata[7:0]}};
        o_rdat = {{24{w_sext}}, w_sh[7:0]};
      end
      SZ_HALF: begin
        w_sext = ~i_funct3[2] & w_sh[15];
        o_sel  = i_lsb[1] ? 4'b1100 : 4'b0011;
        o_wdat = {2{i_wdata[15:0]}};
        o_rdat = {{16{w_sext}}, w_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serv_dbus_ctrl.sv
// Data-bus master stage: collects serial store data, runs one Wishbone
// transaction per load/store and streams load results back serially.
// Optional macro SERV_DBUS_MISALIGN_TRAP_EN: misaligned half/word accesses
// are refused with an o_misalign/o_done pulse instead of a bus cycle.
module serv_dbus_ctrl
  import serv_dbus_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_cmd_valid,
  input  logic                      i_cmd_we,
  input  logic [2:0]                i_funct3,
  input  logic [31:0]               i_adr,
  input  logic [1:0]                i_lsb,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic                      o_busy,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [3:0]                o_wb_sel,
  output logic                      o_wb_we,
  output logic                      o_wb_cyc,
  input  logic [31:0]               i_wb_rdt,
  input  logic                      i_wb_ack,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_rd_valid,
  output logic                      o_done,
  output logic                      o_misalign
);

  localparam int W = BITS_PER_CYCLE;
  localparam logic [5:0] LAST_BEAT = 6'(beat_count(W) - 1);

  state_t      r_state;
  logic [31:0] r_data;
  logic [5:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lsb;
  logic        r_we;
  logic        r_cyc;
  logic        r_done;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [3:0]  r_sel;

  logic [2:0]  w_funct3;
  logic [1:0]  w_lsb;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat;
  logic [31:0] w_rdat;
  logic        w_misalign;

  // In IDLE the lane logic looks at the incoming command; afterwards at the latched one.
  assign w_funct3 = (r_state == ST_IDLE) ? i_funct3 : r_funct3;
  assign w_lsb    = (r_state == ST_IDLE) ? i_lsb    : r_lsb;

  serv_dbus_align u_align (
    .i_funct3 (w_funct3),
    .i_lsb    (w_lsb),
    .i_wdata  (r_data),
    .i_rdt    (i_wb_rdt),
    .o_sel    (w_sel),
    .o_wdat   (w_wdat),
    .o_rdat   (w_rdat)
  );

`ifdef SERV_DBUS_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_misalign = ((i_funct3[1:0] == SZ_HALF) && i_lsb[0]) ||
                      (i_funct3[1] && (i_lsb != 2'b00));

  // One-cycle flag for a refused misaligned command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_misalign <= 1'b0;
    else          r_misalign <= (r_state == ST_IDLE) && i_cmd_valid && w_misalign;
  end

  assign o_misalign = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign o_misalign = 1'b0;
`endif

  // Main control FSM with registered bus outputs and the shared data shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_lsb    <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_done   <= 1'b0;
      r_adr    <= '0;
      r_wdat   <= '0;
      r_sel    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_en) r_data <= {i_rs2, r_data[31:W]};
          if (i_cmd_valid) begin
            if (w_misalign) begin
              r_done <= 1'b1;
            end else begin
              r_adr    <= {i_adr[31:2], 2'b00};
              r_wdat   <= w_wdat;
              r_sel    <= w_sel;
              r_we     <= i_cmd_we;
              r_funct3 <= i_funct3;
              r_lsb    <= i_lsb;
              r_cyc    <= 1'b1;
              r_state  <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (i_wb_ack) begin
            r_cyc <= 1'b0;
            if (r_we) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_data  <= w_rdat;
              r_cnt   <= '0;
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (i_en) begin
            r_data <= {{W{1'b0}}, r_data[31:W]};
            r_cnt  <= r_cnt + 6'd1;
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_wb_adr   = r_adr;
  assign o_wb_dat   = r_wdat;
  assign o_wb_sel   = r_sel;
  assign o_wb_we    = r_we;
  assign o_wb_cyc   = r_cyc;
  assign o_done     = r_done;
  assign o_rd       = r_data[W-1:0];
  assign o_rd_valid = (r_state == ST_RESP) && i_en;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Directed bench for serv_dbus_ctrl: one W=1 instance and one W=4 instance.
module tb_serv_dbus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=1 instance signals
  logic        en1 = 0, cmd1 = 0, we1 = 0, ack1 = 0;
  logic [2:0]  f3_1 = 0;
  logic [1:0]  lsb1 = 0;
  logic [31:0] adr1 = 0, rdt1 = 0;
  logic [0:0]  rs2_1 = 0;
  logic        busy1, we_o1, cyc1, rdv1, done1, mis1;
  logic [31:0] wadr1, wdat1;
  logic [3:0]  sel1;
  logic [0:0]  rd1;

  // W=4 instance signals
  logic        en4 = 0, cmd4 = 0, we4 = 0, ack4 = 0;
  logic [2:0]  f3_4 = 0;
  logic [1:0]  lsb4 = 0;
  logic [31:0] adr4 = 0, rdt4 = 0;
  logic [3:0]  rs2_4 = 0;
  logic        busy4, we_o4, cyc4, rdv4, done4, mis4;
  logic [31:0] wadr4, wdat4;
  logic [3:0]  sel4;
  logic [3:0]  rd4;

  int n_tests = 0;
  int n_fail  = 0;

  serv_dbus_ctrl #(.BITS_PER_CYCLE(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_cmd_valid(cmd1), .i_cmd_we(we1),
    .i_funct3(f3_1), .i_adr(adr1), .i_lsb(lsb1), .i_rs2(rs2_1), .o_busy(busy1),
    .o_wb_adr(wadr1), .o_wb_dat(wdat1), .o_wb_sel(sel1), .o_wb_we(we_o1),
    .o_wb_cyc(cyc1), .i_wb_rdt(rdt1), .i_wb_ack(ack1), .o_rd(rd1),
    .o_rd_valid(rdv1), .o_done(done1), .o_misalign(mis1)
  );

  serv_dbus_ctrl #(.BITS_PER_CYCLE(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_cmd_valid(cmd4), .i_cmd_we(we4),
    .i_funct3(f3_4), .i_adr(adr4), .i_lsb(lsb4), .i_rs2(rs2_4), .o_busy(busy4),
    .o_wb_adr(wadr4), .o_wb_dat(wdat4), .o_wb_sel(sel4), .o_wb_we(we_o4),
    .o_wb_cyc(cyc4), .i_wb_rdt(rdt4), .i_wb_ack(ack4), .o_rd(rd4),
    .o_rd_valid(rdv4), .o_done(done4), .o_misalign(mis4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in1(input logic [31:0] val);
    for (int i = 0; i < 32; i++) begin
      en1 = 1'b1; rs2_1 = val[i];
      tick();
    end
    en1 = 1'b0;
  endtask

  task automatic shift_in4(input logic [31:0] val);
    for (int i = 0; i < 8; i++) begin
      en4 = 1'b1; rs2_4 = val[4*i +: 4];
      tick();
    end
    en4 = 1'b0;
  endtask

  // Store on the W=4 instance with zero-wait ack.
  task automatic store4(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                        input logic [31:0] d, input logic [3:0] exp_sel,
                        input logic [31:0] exp_dat);
    shift_in4(d);
    cmd4 = 1'b1; we4 = 1'b1; f3_4 = f3; lsb4 = lsb; adr4 = 32'h0000_0040;
    tick();
    cmd4 = 1'b0;
    check({tag, "_cyc"}, 32'(cyc4), 32'd1);
    check({tag, "_sel"}, 32'(sel4), 32'(exp_sel));
    check({tag, "_dat"}, wdat4, exp_dat);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check({tag, "_done"}, 32'(done4), 32'd1);
    check({tag, "_cyc_off"}, 32'(cyc4), 32'd0);
    tick();
  endtask

  // Load on the W=4 instance; optional ack delay with i_en toggling in BUS.
  task automatic load4(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic [31:0] rdt, input int delay, input logic [31:0] exp);
    logic [31:0] res;
    cmd4 = 1'b1; we4 = 1'b0; f3_4 = f3; lsb4 = lsb; adr4 = 32'h0000_2000;
    tick();
    cmd4 = 1'b0;
    check({tag, "_cyc"}, 32'(cyc4), 32'd1);
    check({tag, "_adr"}, wadr4, 32'h0000_2000);
    check({tag, "_mis"}, 32'(mis4), 32'd0);
    for (int k = 0; k < delay; k++) begin
      en4 = k[0];
      cmd4 = (k == 1);
      tick();
      check({tag, "_cyc_hold"}, 32'(cyc4), 32'd1);
    end
    en4 = 1'b0; cmd4 = 1'b0;
    rdt4 = rdt; ack4 = 1'b1;
    tick();
    ack4 = 1'b0; rdt4 = 32'hDEAD_BEEF;
    check({tag, "_cyc_off"}, 32'(cyc4), 32'd0);
    res = '0;
    for (int b = 0; b < 8; b++) begin
      tick();
      check({tag, "_rdv_idle"}, 32'(rdv4), 32'd0);
      check({tag, "_busy"}, 32'(busy4), 32'd1);
      check({tag, "_nodone"}, 32'(done4), 32'd0);
      en4 = 1'b1;
      #1;
      check({tag, "_rdv"}, 32'(rdv4), 32'd1);
      res = res | (32'(rd4) << (4 * b));
      tick();
      en4 = 1'b0;
    end
    check({tag, "_data"}, res, exp);
    check({tag, "_done"}, 32'(done4), 32'd1);
    tick();
    check({tag, "_done_off"}, 32'(done4), 32'd0);
    check({tag, "_idle"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_cyc1",  32'(cyc1),  32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_cyc4",  32'(cyc4),  32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_sel4",  32'(sel4),  32'd0);
    check("rst_dat4",  wdat4,      32'd0);
    check("rst_adr4",  wadr4,      32'd0);
    check("rst_mis4",  32'(mis4),  32'd0);
    check("rst_rd4",   32'(rd4),   32'd0);
    rst_n = 1'b1;
    tick();

    // W=1 sb, lsb=2, adr 0x100
    shift_in1(32'h0000_00A5);
    cmd1 = 1'b1; we1 = 1'b1; f3_1 = 3'b000; lsb1 = 2'd2; adr1 = 32'h0000_0100;
    tick();
    cmd1 = 1'b0;
    check("sb_cyc",  32'(cyc1),  32'd1);
    check("sb_we",   32'(we_o1), 32'd1);
    check("sb_sel",  32'(sel1),  32'b0100);
    check("sb_dat",  wdat1,      32'hA5A5_A5A5);
    check("sb_adr",  wadr1,      32'h0000_0100);
    check("sb_done_early", 32'(done1), 32'd0);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("sb_done", 32'(done1), 32'd1);
    check("sb_cyc_off", 32'(cyc1), 32'd0);
    tick();
    check("sb_done_off", 32'(done1), 32'd0);

    // W=4 stores: halfword lsb=0 and word
    store4("sh", 3'b001, 2'd0, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF);
    store4("sh2", 3'b001, 2'd2, 32'h0000_1357, 4'b1100, 32'h1357_1357);
    store4("sw", 3'b010, 2'd0, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // W=4 loads
    load4("lh",  3'b001, 2'd2, 32'h8001_1234, 0, 32'hFFFF_8001);
    load4("lbu", 3'b100, 2'd3, 32'hF000_0000, 0, 32'h0000_00F0);
    load4("lb",  3'b000, 2'd3, 32'hF000_0000, 0, 32'hFFFF_FFF0);
    load4("lhu", 3'b101, 2'd0, 32'h1234_9ABC, 0, 32'h0000_9ABC);
    load4("lw_dly", 3'b010, 2'd0, 32'h1234_5678, 5, 32'h1234_5678);

    // Reset asserted mid-BUS
    cmd4 = 1'b1; we4 = 1'b0; f3_4 = 3'b010; lsb4 = 2'd0; adr4 = 32'h0000_3000;
    tick();
    cmd4 = 1'b0;
    check("rstbus_cyc_pre", 32'(cyc4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstbus_cyc", 32'(cyc4), 32'd0);
    check("rstbus_busy", 32'(busy4), 32'd0);
    tick();
    rst_n = 1'b1;
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check("rstbus_nodone", 32'(done4), 32'd0);
    check("rstbus_idle", 32'(busy4), 32'd0);
    check("rstbus_cyc_stay", 32'(cyc4), 32'd0);
    tick();
    check("rstbus_nodone2", 32'(done4), 32'd0);

    // Misaligned word load
`ifdef SERV_DBUS_MISALIGN_TRAP_EN
    cmd4 = 1'b1; we4 = 1'b0; f3_4 = 3'b010; lsb4 = 2'd1; adr4 = 32'h0000_2000;
    tick();
    cmd4 = 1'b0;
    check("mis_flag", 32'(mis4), 32'd1);
    check("mis_done", 32'(done4), 32'd1);
    check("mis_cyc",  32'(cyc4), 32'd0);
    check("mis_busy", 32'(busy4), 32'd0);
    tick();
    check("mis_flag_off", 32'(mis4), 32'd0);
    check("mis_done_off", 32'(done4), 32'd0);
    check("mis_cyc2", 32'(cyc4), 32'd0);
`else
    load4("lw_mis", 3'b010, 2'd1, 32'h1234_5678, 0, 32'h0012_3456);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
